// File: rtl/arith_result_collector.sv
// arith_result_collector: captures result/status pairs from the arithmetic
// unit into a small FIFO with a valid/ready consumer port, and keeps
// per-status-bit saturating event counters plus a sticky overflow flag.
module arith_result_collector #(
  parameter int unsigned M     = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [M-1:0]             i_result,
  input  logic [3:0]               i_status,
  input  logic                     i_ready,
  input  logic                     i_clear_cnt,
  output logic                     o_valid,
  output logic [M-1:0]             o_data,
  output logic [3:0]               o_stat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic [4*CW-1:0]          o_err_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNTW  = AW + 1;
  localparam int unsigned NSTAT = 4;
  localparam logic [CW-1:0]   CNT_MAX = '1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  logic [M-1:0]    data_mem [DEPTH];
  logic [3:0]      stat_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            do_read;
  logic            do_write;
  logic            do_drop;
  logic [CNTW-1:0] count_nxt;

  // Handshake decode; a full FIFO still accepts when the head pops this cycle
  always_comb begin
    do_read   = o_valid && i_ready;
    do_write  = i_valid && (!o_full || do_read);
    do_drop   = i_valid && o_full && !do_read;
    count_nxt = o_count + CNTW'(do_write) - CNTW'(do_read);
  end

  // Head entry is presented straight from storage; no bypass path
  assign o_data = data_mem[head];
  assign o_stat = stat_mem[head];

  // FIFO storage, pointers and registered occupancy flags
  always_ff @(posedge clk) begin
    if (i_reset) begin
      head    <= '0;
      tail    <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_full  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        stat_mem[i] <= '0;
      end
    end else begin
      if (do_write) begin
        data_mem[tail] <= i_result;
        stat_mem[tail] <= i_status;
        tail           <= tail + AW'(1);
      end
      if (do_read) begin
        head <= head + AW'(1);
      end
      o_count <= count_nxt;
      o_valid <= (count_nxt != '0);
      o_full  <= (count_nxt == DEPTH_C);
    end
  end

  // Saturating event counters and sticky overflow; clear beats any update
  always_ff @(posedge clk) begin
    if (i_reset || i_clear_cnt) begin
      o_err_cnt  <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (do_drop) begin
        o_overflow <= 1'b1;
      end
      for (int unsigned k = 0; k < NSTAT; k++) begin
        if (do_write && i_status[k] && (o_err_cnt[k*CW +: CW] != CNT_MAX)) begin
          o_err_cnt[k*CW +: CW] <= o_err_cnt[k*CW +: CW] + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/arith_result_collector.md
# arith_result_collector

Downstream capture stage for `sync_arith_unit_29`. Each cycle it may accept one `o_result`/`o_status` pair from the arithmetic unit, qualified by a valid strobe. Accepted pairs go into a small FIFO, which presents them to a consumer through a valid/ready handshake. Per-status-bit saturating event counters and a sticky overflow flag support debug and error accounting.

## Interface
- `M`, 32, result width; matches the arithmetic unit's `M`.
- `DEPTH`, 4, FIFO entries; power of two, minimum 2.
- `CW`, 8, width of each status event counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  `i_result`/`i_status` hold a new pair this cycle.
- `i_result`  in  M  connected to the arithmetic unit's `o_result`.
- `i_status`  in  4  connected to the arithmetic unit's `o_status`.
- `i_ready`  in  1  consumer accepts the head entry this cycle.
- `i_clear_cnt`  in  1  clears the event counters and `o_overflow`.
- `o_valid`  out  1  FIFO non-empty; head entry presented.
- `o_data`  out  M  result field of the head entry.
- `o_stat`  out  4  status field of the head entry.
- `o_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `o_full`  out  1  `o_count == DEPTH`.
- `o_overflow`  out  1  sticky; a pair was dropped.
- `o_err_cnt`  out  4*CW  bits `[k*CW +: CW]` = event counter for status bit k.

## Operation
- **Write.** `i_valid && (!o_full || (o_valid && i_ready))` accepts the pair at the tail, tail pointer +1 mod DEPTH.
- **Drop.** `i_valid && o_full && !(o_valid && i_ready)`: the pair is dropped and `o_overflow` is set. The FIFO is unchanged and the counters are not incremented.
- **Read.** `o_valid && i_ready` pops the head entry, head pointer +1 mod DEPTH. `i_ready` while empty has no effect.
- **Simultaneous read and write.** Occupancy is unchanged, including when full (the write is accepted) and when holding one entry.
- **Empty write.** There is no bypass: the written entry appears on `o_data`/`o_stat` with `o_valid=1` in the following cycle.
- **Event counters.** On each accepted write, counter k increments by 1 for every k with `i_status[k]=1`. Counters saturate at 2^CW-1 and never wrap. Dropped pairs never count.
- **Counter clear.** `i_clear_cnt` zeroes all counters and `o_overflow` at the next edge. Clear wins over a simultaneous increment or drop: the counter/flag is 0 after the edge. Clear does not touch FIFO contents.
- **Pointer wrap.** Pointers are `$clog2(DEPTH)` bits and wrap naturally. Full/empty are derived from the occupancy counter, not from pointer equality.
- **Outputs.** `o_data`/`o_stat` are driven from storage at the head pointer and are don't-care while `o_valid=0`. The bench must not check them then.

## Timing
- Reset (synchronous, `i_reset=1` at an edge): pointers and occupancy go to 0. `o_valid=0`, `o_full=0`, `o_count=0`, `o_overflow=0`, `o_err_cnt=0`. `o_data`/`o_stat` read as 0 (storage is cleared).
- Reset has priority over all other inputs in the same cycle. Reset mid-stream discards all queued entries; the pair offered in the reset cycle is not accepted.
- Write-to-visible latency is 1 cycle. `o_count`, `o_full`, `o_valid`, `o_overflow` and `o_err_cnt` are registered and update at the edge following the causing event.
- Throughput is one accept and one pop per cycle, sustained indefinitely.
- Handshake on the consumer side: once `o_valid=1`, `o_data`/`o_stat` stay stable until popped. `o_valid` never drops without a pop or reset.

## Test plan
- **Reset values.** Reset, then idle 3 cycles → all outputs 0, `o_valid=0`.
- **Single pass-through.** `i_valid` with `i_result=18`, `i_status=4'b0001` for 1 cycle, `i_ready=1` → next cycle `o_valid=1`, `o_data=18`, `o_stat=1`, `o_count=1`. One cycle later `o_count=0`, `o_err_cnt[7:0]=1`.
- **Fill and overflow.** `i_ready=0`, write 5 values 1..5 (DEPTH=4) → `o_full=1`, `o_count=4`, `o_overflow=1`. Then `i_ready=1` → pops 1,2,3,4 in order; 5 is never seen.
- **Full with simultaneous read/write.** With the FIFO full, `i_valid=1` carrying 9 and `i_ready=1` → `o_count` stays 4, `o_overflow` stays 0, 9 emerges after 3 more pops.
- **Saturation and clear.** CW=8, 300 accepted writes with `i_status=4'b1000` → `o_err_cnt[31:24]=255`, others 0. Assert `i_clear_cnt` in the same cycle as a write → counters 0 after the edge.
- **Reset mid-stream.** With 3 entries queued, assert `i_reset` together with `i_valid` → next cycle `o_count=0`, `o_valid=0`. The pair offered during reset never appears.
